// File: rtl/id_ex_register_if.sv
// ID/EX pipeline-register bus: decode-side operands and control, write-back
// bypass source, stall/flush controls, and the registered EX-side bundle.
interface id_ex_register_if #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned ALUOP_W    = 4
);
   logic                  Stall;
   logic                  Flush;
   logic                  ID_Valid;
   logic [REG_ADDR_W-1:0] ID_ReadRegister1;
   logic [REG_ADDR_W-1:0] ID_ReadRegister2;
   logic [REG_ADDR_W-1:0] ID_Rd;
   logic [DATA_W-1:0]     ID_ReadData1;
   logic [DATA_W-1:0]     ID_ReadData2;
   logic [DATA_W-1:0]     ID_SignExtImm;
   logic [DATA_W-1:0]     ID_PCPlus4;
   logic                  ID_RegWrite;
   logic                  ID_MemtoReg;
   logic                  ID_MemRead;
   logic                  ID_MemWrite;
   logic                  ID_ALUSrc;
   logic                  ID_RegDst;
   logic [ALUOP_W-1:0]    ID_ALUOp;
   logic                  WB_RegWrite;
   logic [REG_ADDR_W-1:0] WB_WriteRegister;
   logic [DATA_W-1:0]     WB_WriteData;

   logic                  EX_Valid;
   logic [REG_ADDR_W-1:0] EX_Rs;
   logic [REG_ADDR_W-1:0] EX_Rt;
   logic [REG_ADDR_W-1:0] EX_Rd;
   logic [DATA_W-1:0]     EX_ReadData1;
   logic [DATA_W-1:0]     EX_ReadData2;
   logic [DATA_W-1:0]     EX_SignExtImm;
   logic [DATA_W-1:0]     EX_PCPlus4;
   logic                  EX_RegWrite;
   logic                  EX_MemtoReg;
   logic                  EX_MemRead;
   logic                  EX_MemWrite;
   logic                  EX_ALUSrc;
   logic                  EX_RegDst;
   logic [ALUOP_W-1:0]    EX_ALUOp;

   modport master (
      output Stall, Flush, ID_Valid, ID_ReadRegister1, ID_ReadRegister2, ID_Rd,
             ID_ReadData1, ID_ReadData2, ID_SignExtImm, ID_PCPlus4,
             ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_ALUSrc,
             ID_RegDst, ID_ALUOp, WB_RegWrite, WB_WriteRegister, WB_WriteData,
      input  EX_Valid, EX_Rs, EX_Rt, EX_Rd, EX_ReadData1, EX_ReadData2,
             EX_SignExtImm, EX_PCPlus4, EX_RegWrite, EX_MemtoReg, EX_MemRead,
             EX_MemWrite, EX_ALUSrc, EX_RegDst, EX_ALUOp
   );

   modport slave (
      input  Stall, Flush, ID_Valid, ID_ReadRegister1, ID_ReadRegister2, ID_Rd,
             ID_ReadData1, ID_ReadData2, ID_SignExtImm, ID_PCPlus4,
             ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_ALUSrc,
             ID_RegDst, ID_ALUOp, WB_RegWrite, WB_WriteRegister, WB_WriteData,
      output EX_Valid, EX_Rs, EX_Rt, EX_Rd, EX_ReadData1, EX_ReadData2,
             EX_SignExtImm, EX_PCPlus4, EX_RegWrite, EX_MemtoReg, EX_MemRead,
             EX_MemWrite, EX_ALUSrc, EX_RegDst, EX_ALUOp
   );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall hold, flush bubble, and write-back bypass
// (including refresh of held operands while stalled).
module id_ex_register #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned ALUOP_W    = 4
) (
   input logic            Clk,
   input logic            Reset_n,
   id_ex_register_if.slave bus
);
   // Control bits packed as {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst}
   logic                  valid_q, valid_d;
   logic [REG_ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic [DATA_W-1:0]     op1_q, op1_d, op2_q, op2_d;
   logic [DATA_W-1:0]     imm_q, imm_d, pc_q, pc_d;
   logic [5:0]            ctrl_q, ctrl_d;
   logic [ALUOP_W-1:0]    aluop_q, aluop_d;

   logic wb_live;
   logic byp1_id, byp2_id, byp1_ex, byp2_ex;

   // Register 0 is never a bypass source.
   assign wb_live = bus.WB_RegWrite && (bus.WB_WriteRegister != '0);
   assign byp1_id = wb_live && (bus.WB_WriteRegister == bus.ID_ReadRegister1);
   assign byp2_id = wb_live && (bus.WB_WriteRegister == bus.ID_ReadRegister2);
   assign byp1_ex = valid_q && wb_live && (bus.WB_WriteRegister == rs_q);
   assign byp2_ex = valid_q && wb_live && (bus.WB_WriteRegister == rt_q);

   always_comb begin
      valid_d = valid_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rd_d    = rd_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      imm_d   = imm_q;
      pc_d    = pc_q;
      ctrl_d  = ctrl_q;
      aluop_d = aluop_q;
      if (bus.Flush) begin
         valid_d = 1'b0;
         rs_d    = '0;
         rt_d    = '0;
         rd_d    = '0;
         op1_d   = '0;
         op2_d   = '0;
         imm_d   = '0;
         pc_d    = '0;
         ctrl_d  = '0;
         aluop_d = '0;
      end else if (bus.Stall) begin
         // Held operands track a producer that retires during the stall.
         if (byp1_ex) op1_d = bus.WB_WriteData;
         if (byp2_ex) op2_d = bus.WB_WriteData;
      end else begin
         valid_d = bus.ID_Valid;
         rs_d    = bus.ID_ReadRegister1;
         rt_d    = bus.ID_ReadRegister2;
         rd_d    = bus.ID_Rd;
         op1_d   = byp1_id ? bus.WB_WriteData : bus.ID_ReadData1;
         op2_d   = byp2_id ? bus.WB_WriteData : bus.ID_ReadData2;
         imm_d   = bus.ID_SignExtImm;
         pc_d    = bus.ID_PCPlus4;
         ctrl_d  = {bus.ID_RegWrite, bus.ID_MemtoReg, bus.ID_MemRead,
                    bus.ID_MemWrite, bus.ID_ALUSrc, bus.ID_RegDst};
         aluop_d = bus.ID_ALUOp;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         valid_q <= 1'b0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         ctrl_q  <= '0;
         aluop_q <= '0;
      end else begin
         valid_q <= valid_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
         ctrl_q  <= ctrl_d;
         aluop_q <= aluop_d;
      end
   end

   assign bus.EX_Valid      = valid_q;
   assign bus.EX_Rs         = rs_q;
   assign bus.EX_Rt         = rt_q;
   assign bus.EX_Rd         = rd_q;
   assign bus.EX_ReadData1  = op1_q;
   assign bus.EX_ReadData2  = op2_q;
   assign bus.EX_SignExtImm = imm_q;
   assign bus.EX_PCPlus4    = pc_q;
   assign bus.EX_RegWrite   = ctrl_q[5];
   assign bus.EX_MemtoReg   = ctrl_q[4];
   assign bus.EX_MemRead    = ctrl_q[3];
   assign bus.EX_MemWrite   = ctrl_q[2];
   assign bus.EX_ALUSrc     = ctrl_q[1];
   assign bus.EX_RegDst     = ctrl_q[0];
   assign bus.EX_ALUOp      = aluop_q;
endmodule
